// File: rtl/axi_bridge_pkg.sv
// Shared types and helpers for the data-cache to AXI4 single-beat bridge.
package axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW_W = 3'd3,
    ST_B    = 3'd4
  } bridge_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Data arrives already lane-aligned, so only the strobes depend on the address.
  function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/dcache_axi_bridge.sv
// SRAM-like data-cache port to single-beat AXI4 master, one transaction in flight.
// Define DCACHE_AXI_BRIDGE_ERR_EN to add the sticky bus_err output.
//
// state | meaning
// IDLE  | waiting for a cache request; addr_ok follows req
// AR    | read address offered, held until arready
// R     | waiting for the read beat; data_ok when it arrives
// AW_W  | write address and data offered, each retires on its own handshake
// B     | waiting for the write response; data_ok when it arrives
module dcache_axi_bridge
  import axi_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_data_req,
  input  logic                  cache_data_wr,
  input  logic [1:0]            cache_data_size,
  input  logic [ADDR_WIDTH-1:0] cache_data_addr,
  input  logic [DATA_WIDTH-1:0] cache_data_wdata,
  output logic [DATA_WIDTH-1:0] cache_data_rdata,
  output logic                  cache_data_addr_ok,
  output logic                  cache_data_data_ok,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arsize,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
`ifdef DCACHE_AXI_BRIDGE_ERR_EN
  ,
  output logic                  bus_err
`endif
);

  bridge_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  aw_fire, w_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    size_d             = size_q;
    wdata_d            = wdata_q;
    wstrb_d            = wstrb_q;
    aw_done_d          = aw_done_q;
    w_done_d           = w_done_q;
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    cache_data_rdata   = '0;
    arvalid            = 1'b0;
    rready             = 1'b0;
    awvalid            = 1'b0;
    wvalid             = 1'b0;
    bready             = 1'b0;
    aw_fire            = 1'b0;
    w_fire             = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cache_data_addr_ok = cache_data_req;
        if (cache_data_req) begin
          addr_d    = cache_data_addr;
          size_d    = cache_data_size;
          wdata_d   = cache_data_wdata;
          wstrb_d   = gen_wstrb(cache_data_size, cache_data_addr[1:0]);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cache_data_wr ? ST_AW_W : ST_AR;
        end
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid) begin
          cache_data_data_ok = 1'b1;
          cache_data_rdata   = rdata;
          state_d            = ST_IDLE;
        end
      end
      ST_AW_W: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        aw_fire = awvalid && awready;
        w_fire  = wvalid && wready;
        // Either channel may retire first; B waits until both have.
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_B;
        end else begin
          aw_done_d = aw_done_q || aw_fire;
          w_done_d  = w_done_q || w_fire;
        end
      end
      ST_B: begin
        bready = 1'b1;
        if (bvalid) begin
          cache_data_data_ok = 1'b1;
          state_d            = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awsize = {1'b0, size_q};
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

`ifdef DCACHE_AXI_BRIDGE_ERR_EN
  logic bus_err_q;

  // resp[1] covers both SLVERR and DECERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_q <= 1'b0;
    end else if ((rvalid && rready && rresp[1]) || (bvalid && bready && bresp[1])) begin
      bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};
`endif

endmodule
